// File: rtl/avr_ram_arbiter_if.sv
// avr_ram_arbiter_if: CPU, host and RAM-side buses around the data RAM arbiter
interface avr_ram_arbiter_if #(parameter int RAMBITS = 12);
  logic [15:0]        cpu_addr;
  logic               cpu_ren;
  logic               cpu_wen;
  logic [7:0]         cpu_wdata;
  logic [7:0]         cpu_rdata;
  logic               cpu_hold;
  logic               host_req;
  logic               host_we;
  logic [RAMBITS-1:0] host_addr;
  logic [7:0]         host_wdata;
  logic               host_gnt;
  logic               host_rvalid;
  logic [7:0]         host_rdata;
  logic [RAMBITS-1:0] ram_addr;
  logic               ram_wen;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;
  modport slave (
    input  cpu_addr, cpu_ren, cpu_wen, cpu_wdata, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output cpu_rdata, cpu_hold, host_gnt, host_rvalid, host_rdata, ram_addr, ram_wen, ram_wdata
  );
  modport master (
    output cpu_addr, cpu_ren, cpu_wen, cpu_wdata, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  cpu_rdata, cpu_hold, host_gnt, host_rvalid, host_rdata, ram_addr, ram_wen, ram_wdata
  );
endinterface

// File: rtl/avr_ram_arbiter.sv
// avr_ram_arbiter: shares the data RAM between the AVR CPU (priority) and a host port
module avr_ram_arbiter #(
  parameter int RAMBITS  = 12,
  parameter int MAX_WAIT = 8
) (
  input logic               clk,
  input logic               reset_n,
  avr_ram_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2;
  logic [1:0] state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       cpu_busy;
  logic       at_max;
  logic       rvalid_q;
  assign bus.cpu_hold    = state == HOLD;
  assign cpu_busy        = (bus.cpu_ren | bus.cpu_wen) & ~bus.cpu_hold;
  assign bus.host_gnt    = reset_n & bus.host_req & (bus.cpu_hold | ~cpu_busy);
  assign bus.ram_addr    = bus.host_gnt ? bus.host_addr : RAMBITS'(bus.cpu_addr);
  assign bus.ram_wdata   = bus.host_gnt ? bus.host_wdata : bus.cpu_wdata;
  assign bus.ram_wen     = reset_n & (bus.host_gnt ? bus.host_we : bus.cpu_wen & ~bus.cpu_hold);
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = bus.ram_rdata;
  assign bus.cpu_rdata   = bus.ram_rdata;
  assign at_max          = wcnt == 8'(MAX_WAIT);
  // HOLD, a granted wait and a withdrawn request all fall back to IDLE with wcnt cleared
  always_comb begin
    state_nxt = IDLE;
    wcnt_nxt  = 8'd0;
    if (state == IDLE && bus.host_req && cpu_busy) begin
      state_nxt = WAIT;
      wcnt_nxt  = 8'd1;
    end else if (state == WAIT && bus.host_req && !bus.host_gnt) begin
      state_nxt = at_max ? HOLD : WAIT;
      wcnt_nxt  = at_max ? wcnt : wcnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wcnt     <= 8'd0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      rvalid_q <= bus.host_gnt & ~bus.host_we;
    end
  end
endmodule
